// File: rtl/meas_disc_if.sv
// meas_disc_if: per-core sample, acquisition-control and result signals of meas_disc.
interface meas_disc_if #(
   parameter int N_CORES      = 5,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ACC_WIDTH    = 32,
   parameter int LEN_WIDTH    = 12
);
   logic [N_CORES-1:0][SAMPLE_WIDTH-1:0] iq_i;
   logic [N_CORES-1:0]                   iq_valid;
   logic [N_CORES-1:0]                   acq_start;
   logic [N_CORES-1:0][LEN_WIDTH-1:0]    acq_len;
   logic [N_CORES-1:0][ACC_WIDTH-1:0]    thresh;
   logic [N_CORES-1:0]                   meas;
   logic [N_CORES-1:0]                   meas_valid;
   logic [N_CORES-1:0]                   meas_err;
   modport master (
      output iq_i, iq_valid, acq_start, acq_len, thresh,
      input  meas, meas_valid, meas_err
   );
   modport slave (
      input  iq_i, iq_valid, acq_start, acq_len, thresh,
      output meas, meas_valid, meas_err
   );
endinterface

// File: rtl/meas_disc.sv
// meas_disc: per-core integrate-and-threshold state discriminator.
// Each channel sums acq_len I samples with saturation and compares the total to thresh.
module meas_disc #(
   parameter int N_CORES      = 5,
   parameter int SAMPLE_WIDTH = 16,
   parameter int ACC_WIDTH    = 32,
   parameter int LEN_WIDTH    = 12
) (
   input logic        clk,
   input logic        reset,
   meas_disc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;
   state_e                      state_q [N_CORES];
   state_e                      state_d [N_CORES];
   logic signed [ACC_WIDTH-1:0] acc_q   [N_CORES];
   logic signed [ACC_WIDTH-1:0] acc_d   [N_CORES];
   logic signed [ACC_WIDTH-1:0] thr_q   [N_CORES];
   logic signed [ACC_WIDTH-1:0] thr_d   [N_CORES];
   logic [LEN_WIDTH-1:0]        len_q   [N_CORES];
   logic [LEN_WIDTH-1:0]        len_d   [N_CORES];
   logic [LEN_WIDTH-1:0]        cnt_q   [N_CORES];
   logic [LEN_WIDTH-1:0]        cnt_d   [N_CORES];
   logic [N_CORES-1:0]          meas_q, meas_d, mv_q, mv_d, err_q, err_d;
   // One guard bit catches overflow; clamp toward the sign of the true sum.
   function automatic logic signed [ACC_WIDTH-1:0] sat_add(
      input logic signed [ACC_WIDTH-1:0]    a,
      input logic signed [SAMPLE_WIDTH-1:0] s
   );
      logic signed [ACC_WIDTH:0] sum;
      sum = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(s);
      return (sum[ACC_WIDTH] == sum[ACC_WIDTH-1]) ? sum[ACC_WIDTH-1:0]
                                                  : {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}};
   endfunction
   always_comb begin
      meas_d = meas_q;
      mv_d   = '0;
      err_d  = err_q;
      for (int c = 0; c < N_CORES; c++) begin
         state_d[c] = state_q[c];
         acc_d[c]   = acc_q[c];
         cnt_d[c]   = cnt_q[c];
         len_d[c]   = len_q[c];
         thr_d[c]   = thr_q[c];
         err_d[c]   = err_q[c] | (bus.acq_start[c] & (state_q[c] != IDLE));
         unique case (state_q[c])
            IDLE: if (bus.acq_start[c]) begin
               len_d[c]   = bus.acq_len[c];
               thr_d[c]   = bus.thresh[c];
               acc_d[c]   = '0;
               cnt_d[c]   = '0;
               state_d[c] = (bus.acq_len[c] != '0) ? ACCUM : DONE;
            end
            ACCUM: if (bus.iq_valid[c]) begin
               acc_d[c] = sat_add(acc_q[c], bus.iq_i[c]);
               cnt_d[c] = cnt_q[c] + LEN_WIDTH'(1);
               if (cnt_q[c] + LEN_WIDTH'(1) == len_q[c]) state_d[c] = DONE;
            end
            DONE: begin
               meas_d[c]  = (acc_q[c] >= thr_q[c]);
               mv_d[c]    = 1'b1;
               state_d[c] = IDLE;
            end
            default: state_d[c] = IDLE;
         endcase
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < N_CORES; c++) begin
            state_q[c] <= IDLE;
            acc_q[c]   <= '0;
            thr_q[c]   <= '0;
            len_q[c]   <= '0;
            cnt_q[c]   <= '0;
         end
         meas_q <= '0;
         mv_q   <= '0;
         err_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         thr_q   <= thr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         meas_q  <= meas_d;
         mv_q    <= mv_d;
         err_q   <= err_d;
      end
   end
   assign bus.meas       = meas_q;
   assign bus.meas_valid = mv_q;
   assign bus.meas_err   = err_q;
endmodule

// File: tb/tb_meas_disc.sv
// tb_meas_disc: randomized and directed bench for meas_disc against a transaction-level model.
// Two DUTs share stimulus: default widths and a 20-bit accumulator for saturation runs.
module tb_meas_disc;
   localparam int N = 5, SW = 16, AW = 32, AWB = 20, LW = 12, MAXC = 64;
   logic clk, reset;
   int   errors, checks;
   bit                   st  [MAXC][N];
   bit                   vl  [MAXC][N];
   logic signed [SW-1:0] smp [MAXC][N];
   logic [LW-1:0]        ln  [MAXC][N];
   logic signed [AW-1:0] th  [MAXC][N];
   logic [N-1:0] got_mv [2][MAXC];
   logic [N-1:0] got_me [2][MAXC];
   logic [N-1:0] got_er [2][MAXC];
   logic [N-1:0] ex_mv  [2][MAXC];
   logic [N-1:0] ex_me  [2][MAXC];
   logic [N-1:0] ex_er  [2][MAXC];
   meas_disc_if #(.N_CORES(N), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AW),  .LEN_WIDTH(LW)) ifa ();
   meas_disc_if #(.N_CORES(N), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AWB), .LEN_WIDTH(LW)) ifb ();
   meas_disc #(.N_CORES(N), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AW),  .LEN_WIDTH(LW)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
   meas_disc #(.N_CORES(N), .SAMPLE_WIDTH(SW), .ACC_WIDTH(AWB), .LEN_WIDTH(LW)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic zero_inputs();
      ifa.acq_start = '0; ifa.iq_valid = '0; ifa.iq_i = '0; ifa.acq_len = '0; ifa.thresh = '0;
      ifb.acq_start = '0; ifb.iq_valid = '0; ifb.iq_i = '0; ifb.acq_len = '0; ifb.thresh = '0;
   endtask
   task automatic clear_plan();
      for (int c = 0; c < MAXC; c++)
         for (int ch = 0; ch < N; ch++) begin
            st[c][ch] = 1'b0; vl[c][ch] = 1'b0; smp[c][ch] = '0; ln[c][ch] = '0; th[c][ch] = '0;
         end
   endtask
   task automatic do_reset();
      reset = 1'b1;
      zero_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_plan();
   endtask
   // Cycle c: outputs observed mid-cycle, then inputs for cycle c applied.
   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         got_mv[0][c] = ifa.meas_valid; got_me[0][c] = ifa.meas; got_er[0][c] = ifa.meas_err;
         got_mv[1][c] = ifb.meas_valid; got_me[1][c] = ifb.meas; got_er[1][c] = ifb.meas_err;
         for (int ch = 0; ch < N; ch++) begin
            ifa.acq_start[ch] = st[c][ch]; ifa.iq_valid[ch] = vl[c][ch]; ifa.iq_i[ch] = smp[c][ch];
            ifa.acq_len[ch] = ln[c][ch]; ifa.thresh[ch] = th[c][ch];
            ifb.acq_start[ch] = st[c][ch]; ifb.iq_valid[ch] = vl[c][ch]; ifb.iq_i[ch] = smp[c][ch];
            ifb.acq_len[ch] = ln[c][ch]; ifb.thresh[ch] = th[c][ch][AWB-1:0];
         end
      end
   endtask
   // Transaction model: an accepted start owns the channel until its pulse; the pulse lands
   // two cycles after the final accepted sample (or after the start for zero length).
   task automatic model(input int n);
      longint hi, lo, acc, thr;
      int busy_end, err_at, k, f;
      for (int d = 0; d < 2; d++) begin
         hi = (longint'(1) <<< ((d == 1 ? AWB : AW) - 1)) - 1;
         lo = -hi - 1;
         for (int c = 0; c < MAXC; c++) begin ex_mv[d][c] = '0; ex_me[d][c] = '0; ex_er[d][c] = '0; end
         for (int ch = 0; ch < N; ch++) begin
            busy_end = -1;
            err_at = MAXC;
            for (int c = 0; c < n; c++) begin
               if (st[c][ch]) begin
                  if (c <= busy_end) begin
                     if (c + 1 < err_at) err_at = c + 1;
                  end else begin
                     acc = 0; k = 0;
                     f = (ln[c][ch] == '0) ? c : -1;
                     for (int j = c + 1; j < n && f < 0; j++)
                        if (vl[j][ch]) begin
                           acc += smp[j][ch];
                           if (acc > hi) acc = hi;
                           if (acc < lo) acc = lo;
                           k++;
                           if (k == int'(ln[c][ch])) f = j;
                        end
                     thr = (d == 1) ? longint'($signed(th[c][ch][AWB-1:0])) : longint'(th[c][ch]);
                     busy_end = (f < 0) ? MAXC : f + 1;
                     if (f >= 0 && f + 2 < MAXC) begin
                        ex_mv[d][f+2][ch] = 1'b1;
                        for (int m = f + 2; m < MAXC; m++) ex_me[d][m][ch] = (acc >= thr);
                     end
                  end
               end
            end
            for (int c = err_at; c < MAXC; c++) ex_er[d][c][ch] = 1'b1;
         end
      end
   endtask
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks += 2;
      if ({ifa.meas, ifa.meas_valid, ifa.meas_err} !== '0) begin errors++; $display("FAIL reset_held dut0: got %b expected 0", {ifa.meas, ifa.meas_valid, ifa.meas_err}); end
      if ({ifb.meas, ifb.meas_valid, ifb.meas_err} !== '0) begin errors++; $display("FAIL reset_held dut1: got %b expected 0", {ifb.meas, ifb.meas_valid, ifb.meas_err}); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks += 2;
      if ({ifa.meas, ifa.meas_valid, ifa.meas_err} !== '0) begin errors++; $display("FAIL reset_released dut0: got %b expected 0", {ifa.meas, ifa.meas_valid, ifa.meas_err}); end
      if ({ifb.meas, ifb.meas_valid, ifb.meas_err} !== '0) begin errors++; $display("FAIL reset_released dut1: got %b expected 0", {ifb.meas, ifb.meas_valid, ifb.meas_err}); end
   endtask
   task automatic test_basic();
      do_reset();
      st[1][0] = 1'b1; ln[1][0] = 12'd4; th[1][0] = 32'sd100;
      vl[2][0] = 1'b1; smp[2][0] = 16'sd10;
      vl[3][0] = 1'b1; smp[3][0] = 16'sd20;
      vl[4][0] = 1'b1; smp[4][0] = 16'sd30;
      vl[5][0] = 1'b1; smp[5][0] = 16'sd50;
      run(10); model(10);
      checks += 2;
      if (got_mv[0][7] !== 5'b00001) begin errors++; $display("FAIL basic pulse: got %b expected 00001", got_mv[0][7]); end
      if (got_me[0][7][0] !== 1'b1) begin errors++; $display("FAIL basic meas: got %b expected 1", got_me[0][7][0]); end
      for (int c = 0; c < 10; c++)
         for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL basic meas_valid dut%0d cycle %0d: got %b expected %b", d, c, got_mv[d][c], ex_mv[d][c]); end
            if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL basic meas dut%0d cycle %0d: got %b expected %b", d, c, got_me[d][c], ex_me[d][c]); end
            if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL basic meas_err dut%0d cycle %0d: got %b expected %b", d, c, got_er[d][c], ex_er[d][c]); end
         end
   endtask
   task automatic test_gap();
      do_reset();
      st[1][2] = 1'b1; ln[1][2] = 12'd3; th[1][2] = 32'sd0;
      vl[2][2] = 1'b1; smp[2][2] = -16'sd5;
      vl[6][2] = 1'b1; smp[6][2] = -16'sd5;
      vl[7][2] = 1'b1; smp[7][2] = -16'sd5;
      run(13); model(13);
      checks += 2;
      if (got_mv[0][9] !== 5'b00100) begin errors++; $display("FAIL gap pulse: got %b expected 00100", got_mv[0][9]); end
      if (got_me[0][9] !== 5'b00000) begin errors++; $display("FAIL gap meas: got %b expected 00000", got_me[0][9]); end
      for (int c = 0; c < 13; c++)
         for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL gap meas_valid dut%0d cycle %0d: got %b expected %b", d, c, got_mv[d][c], ex_mv[d][c]); end
            if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL gap meas dut%0d cycle %0d: got %b expected %b", d, c, got_me[d][c], ex_me[d][c]); end
            if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL gap meas_err dut%0d cycle %0d: got %b expected %b", d, c, got_er[d][c], ex_er[d][c]); end
         end
   endtask
   task automatic test_saturation();
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         st[1][1] = 1'b1; ln[1][1] = 12'd40;
         th[1][1] = (pass == 0) ? 32'sd524287 : -32'sd524287;
         for (int c = 2; c < 42; c++) begin
            vl[c][1] = 1'b1;
            smp[c][1] = (pass == 0) ? 16'sd32767 : -16'sd32768;
         end
         run(46); model(46);
         checks += 2;
         if (got_mv[1][43] !== 5'b00010) begin errors++; $display("FAIL sat%0d pulse: got %b expected 00010", pass, got_mv[1][43]); end
         if (got_me[1][43][1] !== (pass == 0)) begin errors++; $display("FAIL sat%0d meas: got %b expected %b", pass, got_me[1][43][1], pass == 0); end
         for (int c = 0; c < 46; c++)
            for (int d = 0; d < 2; d++) begin
               checks += 3;
               if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL sat%0d meas_valid dut%0d cycle %0d: got %b expected %b", pass, d, c, got_mv[d][c], ex_mv[d][c]); end
               if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL sat%0d meas dut%0d cycle %0d: got %b expected %b", pass, d, c, got_me[d][c], ex_me[d][c]); end
               if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL sat%0d meas_err dut%0d cycle %0d: got %b expected %b", pass, d, c, got_er[d][c], ex_er[d][c]); end
            end
      end
   endtask
   task automatic test_err();
      do_reset();
      st[1][3] = 1'b1; ln[1][3] = 12'd5; th[1][3] = 32'sd40;
      for (int c = 2; c < 7; c++) begin vl[c][3] = 1'b1; smp[c][3] = 16'sd10; end
      st[4][3] = 1'b1; ln[4][3] = 12'd1; th[4][3] = 32'sd1000;
      st[10][3] = 1'b1; ln[10][3] = 12'd2; th[10][3] = 32'sd3;
      vl[11][3] = 1'b1; smp[11][3] = -16'sd1;
      vl[12][3] = 1'b1; smp[12][3] = -16'sd1;
      run(17); model(17);
      checks += 4;
      if (got_er[0][4][3] !== 1'b0) begin errors++; $display("FAIL err early: got %b expected 0", got_er[0][4][3]); end
      if (got_er[0][5] !== 5'b01000) begin errors++; $display("FAIL err set: got %b expected 01000", got_er[0][5]); end
      if (got_mv[0][8] !== 5'b01000 || got_me[0][8][3] !== 1'b1) begin errors++; $display("FAIL err first result: got mv %b meas %b expected 01000/1", got_mv[0][8], got_me[0][8][3]); end
      if (got_mv[0][14] !== 5'b01000 || got_me[0][14][3] !== 1'b0) begin errors++; $display("FAIL err second result: got mv %b meas %b expected 01000/0", got_mv[0][14], got_me[0][14][3]); end
      for (int c = 0; c < 17; c++)
         for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL err meas_valid dut%0d cycle %0d: got %b expected %b", d, c, got_mv[d][c], ex_mv[d][c]); end
            if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL err meas dut%0d cycle %0d: got %b expected %b", d, c, got_me[d][c], ex_me[d][c]); end
            if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL err meas_err dut%0d cycle %0d: got %b expected %b", d, c, got_er[d][c], ex_er[d][c]); end
         end
   endtask
   task automatic test_zero_len_reset();
      do_reset();
      st[1][4] = 1'b1; ln[1][4] = 12'd0; th[1][4] = -32'sd1;
      st[5][4] = 1'b1; ln[5][4] = 12'd8; th[5][4] = 32'sd0;
      for (int c = 6; c < 10; c++) begin vl[c][4] = 1'b1; smp[c][4] = 16'sd100; end
      run(11); model(11);
      checks += 1;
      if (got_mv[0][3] !== 5'b10000 || got_me[0][3][4] !== 1'b1) begin errors++; $display("FAIL zlen result: got mv %b meas %b expected 10000/1", got_mv[0][3], got_me[0][3][4]); end
      for (int c = 0; c < 11; c++)
         for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL zlen meas_valid dut%0d cycle %0d: got %b expected %b", d, c, got_mv[d][c], ex_mv[d][c]); end
            if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL zlen meas dut%0d cycle %0d: got %b expected %b", d, c, got_me[d][c], ex_me[d][c]); end
            if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL zlen meas_err dut%0d cycle %0d: got %b expected %b", d, c, got_er[d][c], ex_er[d][c]); end
         end
      #2 reset = 1'b1;
      #1;
      checks += 2;
      if ({ifa.meas, ifa.meas_valid, ifa.meas_err} !== '0) begin errors++; $display("FAIL async_reset dut0: got %b expected 0", {ifa.meas, ifa.meas_valid, ifa.meas_err}); end
      if ({ifb.meas, ifb.meas_valid, ifb.meas_err} !== '0) begin errors++; $display("FAIL async_reset dut1: got %b expected 0", {ifb.meas, ifb.meas_valid, ifb.meas_err}); end
      zero_inputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks += 1;
         if ({ifa.meas, ifa.meas_valid, ifb.meas_valid} !== '0) begin errors++; $display("FAIL reset_abort cycle %0d: got %b expected 0", i, {ifa.meas, ifa.meas_valid, ifb.meas_valid}); end
      end
      reset = 1'b0;
      clear_plan();
      st[1][4] = 1'b1; ln[1][4] = 12'd1; th[1][4] = 32'sd5;
      vl[2][4] = 1'b1; smp[2][4] = 16'sd7;
      run(8); model(8);
      checks += 1;
      if (got_mv[0][4] !== 5'b10000 || got_me[0][4][4] !== 1'b1) begin errors++; $display("FAIL post_reset result: got mv %b meas %b expected 10000/1", got_mv[0][4], got_me[0][4][4]); end
      for (int c = 0; c < 8; c++)
         for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL post_reset meas_valid dut%0d cycle %0d: got %b expected %b", d, c, got_mv[d][c], ex_mv[d][c]); end
            if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL post_reset meas dut%0d cycle %0d: got %b expected %b", d, c, got_me[d][c], ex_me[d][c]); end
            if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL post_reset meas_err dut%0d cycle %0d: got %b expected %b", d, c, got_er[d][c], ex_er[d][c]); end
         end
   endtask
   task automatic test_all_start();
      int lens [N] = '{3, 0, 5, 1, 4};
      do_reset();
      for (int ch = 0; ch < N; ch++) begin
         st[1][ch] = 1'b1;
         ln[1][ch] = LW'(lens[ch]);
         th[1][ch] = 32'($urandom_range(60000)) - 32'sd30000;
         for (int c = 1; c < 30; c++) begin
            vl[c][ch] = ($urandom_range(3) != 0);
            smp[c][ch] = 16'($urandom_range(40000)) - 16'sd20000;
         end
      end
      run(36); model(36);
      for (int c = 0; c < 36; c++)
         for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL all_start meas_valid dut%0d cycle %0d: got %b expected %b", d, c, got_mv[d][c], ex_mv[d][c]); end
            if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL all_start meas dut%0d cycle %0d: got %b expected %b", d, c, got_me[d][c], ex_me[d][c]); end
            if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL all_start meas_err dut%0d cycle %0d: got %b expected %b", d, c, got_er[d][c], ex_er[d][c]); end
         end
   endtask
   task automatic test_back_to_back();
      for (int it = 0; it < 8; it++) begin
         do_reset();
         for (int c = 0; c < 44; c++)
            for (int ch = 0; ch < N; ch++) begin
               st[c][ch] = ($urandom_range(5) == 0);
               vl[c][ch] = ($urandom_range(3) != 0);
               smp[c][ch] = 16'($urandom);
               ln[c][ch] = LW'($urandom_range(5));
               th[c][ch] = 32'($urandom_range(120000)) - 32'sd60000;
            end
         run(48); model(48);
         for (int c = 0; c < 48; c++)
            for (int d = 0; d < 2; d++) begin
               checks += 3;
               if (got_mv[d][c] !== ex_mv[d][c]) begin errors++; $display("FAIL b2b%0d meas_valid dut%0d cycle %0d: got %b expected %b", it, d, c, got_mv[d][c], ex_mv[d][c]); end
               if (got_me[d][c] !== ex_me[d][c]) begin errors++; $display("FAIL b2b%0d meas dut%0d cycle %0d: got %b expected %b", it, d, c, got_me[d][c], ex_me[d][c]); end
               if (got_er[d][c] !== ex_er[d][c]) begin errors++; $display("FAIL b2b%0d meas_err dut%0d cycle %0d: got %b expected %b", it, d, c, got_er[d][c], ex_er[d][c]); end
            end
      end
   endtask
   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      zero_inputs();
      clear_plan();
      test_reset();
      test_basic();
      test_gap();
      test_saturation();
      test_err();
      test_zero_len_reset();
      test_all_start();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/meas_disc.md
MEAS_DISC -- requirements
Module: meas_disc

Interface
REQ-001 Parameter N_CORES, default 5: number of independent measurement channels, one per processor core.
REQ-002 Parameter SAMPLE_WIDTH, default 16: signed width of each demodulated I sample.
REQ-003 Parameter ACC_WIDTH, default 32: signed accumulator and threshold width; must be at least SAMPLE_WIDTH+1.
REQ-004 Parameter LEN_WIDTH, default 12: width of the acquisition-length field.
REQ-005 Port clk, input, 1: single clock for all logic.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port iq_i[N_CORES-1:0], input, SAMPLE_WIDTH each: signed, rotated I sample per channel.
REQ-008 Port iq_valid, input, N_CORES: per-channel sample strobe.
REQ-009 Port acq_start, input, N_CORES: per-channel single-cycle acquisition request.
REQ-010 Port acq_len[N_CORES-1:0], input, LEN_WIDTH each: number of valid samples to integrate; sampled on an accepted start.
REQ-011 Port thresh[N_CORES-1:0], input, ACC_WIDTH each: signed discrimination threshold; sampled on an accepted start.
REQ-012 Port meas, output, N_CORES: discriminated state bit; this port connects directly to the fproc_meas meas input.
REQ-013 Port meas_valid, output, N_CORES: one-cycle pulse qualifying meas; this port connects directly to the fproc_meas meas_valid input.
REQ-014 Port meas_err, output, N_CORES: sticky flag indicating an acq_start was dropped.

Function
REQ-015 Each channel shall run an independent FSM with states IDLE, ACCUM and DONE; channels shall share no state.
REQ-016 IDLE with acq_start=1 -> capture acq_len and thresh, clear the accumulator and sample count; next state is ACCUM if acq_len != 0, otherwise DONE.
REQ-017 In ACCUM, each cycle with iq_valid=1 shall add the sign-extended iq_i to the accumulator and increment the count; cycles with iq_valid=0 leave both unchanged.
REQ-018 Accumulation shall saturate at the most positive and most negative ACC_WIDTH values; it shall never wrap.
REQ-019 ACCUM -> DONE on the edge that accepts the sample bringing the count to the latched length; further samples are ignored until the next start.
REQ-020 In DONE, at the next edge: meas <= (acc >= latched thresh, signed compare); meas_valid <= 1; state -> IDLE.
REQ-021 meas_valid shall be high for exactly one cycle per accepted start; meas shall hold its value until the next result.
REQ-022 Latency: when the final sample is presented in cycle k, meas_valid shall be high in cycle k+2; with acq_len=0 and the start in cycle k, meas_valid shall be high in cycle k+2 and the result compares 0 >= thresh.
REQ-023 An acq_start in ACCUM or DONE shall be ignored, shall set the channel's meas_err, and shall not disturb the acquisition in progress.
REQ-024 Changes to acq_len or thresh after an accepted start shall have no effect on the acquisition in progress.
REQ-025 iq_valid and acq_start asserted together in IDLE: the sample in that cycle shall not be accumulated.
REQ-026 Simultaneous events on different channels shall produce fully independent results in the same cycle.

Reset
REQ-027 Asserting reset shall immediately force every channel to IDLE and clear the accumulator, count, meas, meas_valid and meas_err to 0.
REQ-028 Reset during ACCUM or DONE shall abort the acquisition with no meas_valid pulse; the first start after reset deasserts shall be accepted normally.

Verification
REQ-029 Ch0: thresh=100, acq_len=4, samples 10, 20, 30, 50 on consecutive cycles -> acc=110, meas[0]=1, meas_valid[0] pulses 2 cycles after the sample 50.
REQ-030 Ch2: thresh=0, acq_len=3, samples -5, gap of 3 invalid cycles, -5, -5 -> meas[2]=0 with a single meas_valid pulse; channels 0, 1, 3 and 4 stay quiet.
REQ-031 Ch1 with ACC_WIDTH=20: 40 samples of +32767 -> acc saturates at 524287, no wrap; thresh=524287 -> meas[1]=1.
REQ-032 Ch3: acq_len=5; a second acq_start after 2 samples -> meas_err[3]=1, result still produced after sample 5; a subsequent start in IDLE is accepted.
REQ-033 Ch4: acq_len=0, thresh=-1 -> meas[4]=1 two cycles after the start; then reset asserted mid-ACCUM of a new acq_len=8 run -> no meas_valid pulse and all outputs 0.
REQ-034 All 5 channels started in the same cycle with different lengths and thresholds -> each result matches a reference model, and meas_valid pulses occur in the expected cycles.
